// File: rtl/e_muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the RV32M multiply/divide unit.
interface e_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  E_start;
  logic [2:0]            E_op;
  logic [DATA_WIDTH-1:0] E_a;
  logic [DATA_WIDTH-1:0] E_b;
  logic                  E_flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  stall_req;

  modport master (
    output E_start, E_op, E_a, E_b, E_flush,
    input  busy, done, result, stall_req
  );

  modport slave (
    input  E_start, E_op, E_a, E_b, E_flush,
    output busy, done, result, stall_req
  );
endinterface

// File: rtl/e_muldiv_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise ops 4-7 complete at once with result 0.
module e_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  e_muldiv_unit_if.slave bus
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      op_r;
  logic            neg_r;
  logic [W-1:0]    opd_r;      // multiplicand or divisor magnitude
  logic [2*W-1:0]  acc_r;      // {product hi, multiplier} or {remainder, quotient}
  logic [4:0]      cnt_r;
  logic            last_r;
  logic [W-1:0]    result_r;

  logic            a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_s;
  logic [W-1:0]    a_mag_s, b_mag_s;
  logic            special_s;
  logic [W-1:0]    special_val_s;
  logic            load_s, step_s, spec_wr_s, fin_wr_s;
  logic [W:0]      mul_sum_s;
  logic [2*W-1:0]  acc_step_s, mul_full_s;
  logic [W-1:0]    fin_val_s;
`ifdef MULDIV_DIV_EN
  logic [W:0]      div_rem_s;
  logic [W-1:0]    div_sub_s;
  logic [W-1:0]    quo_s, rem_s;
`endif

  // Operand signedness, magnitudes and result sign of the offered op
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (bus.E_op)
      3'd1, 3'd4, 3'd6: begin
        a_sgn_s = 1'b1;
        b_sgn_s = 1'b1;
      end
      3'd2: a_sgn_s = 1'b1;
      default: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
      end
    endcase
    a_neg_s = a_sgn_s & bus.E_a[W-1];
    b_neg_s = b_sgn_s & bus.E_b[W-1];
    if (a_neg_s) a_mag_s = -bus.E_a;
    else         a_mag_s = bus.E_a;
    if (b_neg_s) b_mag_s = -bus.E_b;
    else         b_mag_s = bus.E_b;
    case (bus.E_op)
      3'd1, 3'd2, 3'd4: neg_s = a_neg_s ^ b_neg_s;
      3'd6:             neg_s = a_neg_s;
      default:          neg_s = 1'b0;
    endcase
  end

  // Ops that complete without iterating
  always_comb begin
    special_s     = 1'b0;
    special_val_s = {W{1'b0}};
`ifdef MULDIV_DIV_EN
    if (bus.E_op[2] && (bus.E_b == {W{1'b0}})) begin
      special_s = 1'b1;
      if (bus.E_op[1]) special_val_s = bus.E_a;
      else             special_val_s = {W{1'b1}};
    end else if (bus.E_op[2] && !bus.E_op[0] &&
                 (bus.E_a == {1'b1, {(W-1){1'b0}}}) && (bus.E_b == {W{1'b1}})) begin
      // Signed overflow: quotient is the dividend itself, remainder zero
      special_s = 1'b1;
      if (bus.E_op[1]) special_val_s = {W{1'b0}};
      else             special_val_s = bus.E_a;
    end else begin
      special_s = 1'b0;
    end
`else
    if (bus.E_op[2]) special_s = 1'b1;
    else             special_s = 1'b0;
`endif
  end

  // One iteration of the shared accumulator
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opd_r} : {(W+1){1'b0}});
    acc_step_s = {mul_sum_s, acc_r[W-1:1]};
`ifdef MULDIV_DIV_EN
    div_rem_s = acc_r[2*W-1:W-1];
    div_sub_s = div_rem_s[W-1:0] - opd_r;
    if (op_r[2]) begin
      if (div_rem_s >= {1'b0, opd_r}) acc_step_s = {div_sub_s, acc_r[W-2:0], 1'b1};
      else                            acc_step_s = {acc_r[2*W-2:0], 1'b0};
    end else begin
      acc_step_s = {mul_sum_s, acc_r[W-1:1]};
    end
`endif
  end

  // Sign correction and result select once all bits are done
  always_comb begin
    if (neg_r) mul_full_s = -acc_r;
    else       mul_full_s = acc_r;
`ifdef MULDIV_DIV_EN
    if (neg_r) begin
      quo_s = -acc_r[W-1:0];
      rem_s = -acc_r[2*W-1:W];
    end else begin
      quo_s = acc_r[W-1:0];
      rem_s = acc_r[2*W-1:W];
    end
`endif
    case (op_r)
      3'd0:             fin_val_s = mul_full_s[W-1:0];
      3'd1, 3'd2, 3'd3: fin_val_s = mul_full_s[2*W-1:W];
`ifdef MULDIV_DIV_EN
      3'd4, 3'd5:       fin_val_s = quo_s;
      3'd6, 3'd7:       fin_val_s = rem_s;
`endif
      default:          fin_val_s = {W{1'b0}};
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    step_s    = 1'b0;
    spec_wr_s = 1'b0;
    fin_wr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.E_start && !bus.E_flush) begin
          if (special_s) begin
            state_s   = DONE;
            spec_wr_s = 1'b1;
          end else begin
            state_s = RUN;
            load_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (bus.E_flush) begin
          state_s = IDLE;
        end else if (last_r) begin
          state_s  = DONE;
          fin_wr_s = 1'b1;
        end else begin
          state_s = RUN;
          step_s  = 1'b1;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Operand latch and iteration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r   <= 3'd0;
      neg_r  <= 1'b0;
      opd_r  <= {W{1'b0}};
      acc_r  <= {(2*W){1'b0}};
      cnt_r  <= 5'd0;
      last_r <= 1'b0;
    end else if (load_s) begin
      op_r   <= bus.E_op;
      neg_r  <= neg_s;
      opd_r  <= bus.E_op[2] ? b_mag_s : a_mag_s;
      acc_r  <= {{W{1'b0}}, (bus.E_op[2] ? a_mag_s : b_mag_s)};
      cnt_r  <= 5'd0;
      last_r <= 1'b0;
    end else if (step_s) begin
      acc_r <= acc_step_s;
      if (cnt_r == 5'd31) last_r <= 1'b1;
      else                cnt_r  <= cnt_r + 5'd1;
    end
  end

  // Result register, written only on entry to DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           result_r <= {W{1'b0}};
    else if (spec_wr_s) result_r <= special_val_s;
    else if (fin_wr_s)  result_r <= fin_val_s;
  end

  assign bus.busy      = (state_r == RUN);
  assign bus.done      = (state_r == DONE);
  assign bus.result    = result_r;
  assign bus.stall_req = bus.E_start && (state_r != DONE);

endmodule

// File: doc/e_muldiv_unit.md
E_MULDIV_UNIT -- requirements
Module: e_muldiv_unit

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port E_start  input  1  execute-stage instruction is an RV32M op; held high until done.
REQ-005 The block SHALL have port E_op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 The block SHALL have port E_a  input  DATA_WIDTH  rs1 operand (forwarded value).
REQ-007 The block SHALL have port E_b  input  DATA_WIDTH  rs2 operand (forwarded value).
REQ-008 The block SHALL have port E_flush  input  1  kill the in-flight op (branch/jump redirect).
REQ-009 The block SHALL have port busy  output  1  iteration in progress.
REQ-010 The block SHALL have port done  output  1  single-cycle pulse; result valid.
REQ-011 The block SHALL have port result  output  DATA_WIDTH  op result, held until next accepted start.
REQ-012 The block SHALL have port stall_req  output  1  to hazard unit; deasserts F_D/D_E enables while high.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
- IDLE->RUN on E_start && !E_flush; operands latched.
- IDLE->DONE directly for special cases (REQ-018, REQ-019).
- RUN->DONE after 32 iterations, counted by a 5-bit counter from 0 to 31.
- DONE->IDLE unconditionally.
REQ-014 Operand latch: magnitudes |E_a|, |E_b| taken per signedness of E_op; result sign SHALL be computed at latch time.
- MULH: both signed. MULHSU: a signed, b unsigned. DIV/REM: both signed.
REQ-015 Multiply SHALL be radix-2 shift-add into a 64-bit product, one bit per RUN cycle.
- MUL returns product[31:0].
- MULH* return product[63:32] after sign correction (two's complement of the full 64 bits).
REQ-016 Divide SHALL be restoring, one quotient bit per RUN cycle.
- Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
REQ-017 Latency SHALL be 33 cycles for the normal path: start accepted at edge N, done high in the cycle after edge N+33.
REQ-018 Divide by zero SHALL reach DONE after 1 cycle.
- DIV/DIVU result = 0xFFFFFFFF.
- REM/REMU result = E_a.
REQ-019 Signed overflow (DIV/REM, E_a=0x80000000, E_b=0xFFFFFFFF) SHALL reach DONE after 1 cycle.
- DIV result = 0x80000000. REM result = 0.
REQ-020 Outputs:
- busy = (state==RUN).
- done = (state==DONE).
- stall_req = E_start && !done, combinational.
REQ-021 E_flush in RUN or DONE SHALL force IDLE on the next edge with no done pulse; result is unchanged.
- E_flush together with E_start in IDLE SHALL NOT accept the op.
REQ-022 E_a, E_b and E_op changes after acceptance SHALL be ignored until return to IDLE.
REQ-023 E_start high in the cycle following done SHALL be treated as a new instruction.
- The D_E register has advanced by then, so this is not a repeat of the completed op.

Reset
REQ-024 rst low SHALL asynchronously force:
- state=IDLE, counter=0, result=0, busy=0, done=0.
- All operand/accumulator registers = 0.
REQ-025 Reset asserted mid-RUN SHALL abort the op; no done pulse SHALL follow reset release.

Configuration
REQ-026 Macro MULDIV_DIV_EN defined: full RV32M support as above.
REQ-027 Macro MULDIV_DIV_EN undefined: divider datapath SHALL be absent.
- E_op 4-7 SHALL go IDLE->DONE in 1 cycle with result=0.
- Multiply behaviour SHALL be unchanged.

Verification
REQ-028 MUL E_a=7, E_b=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 cycles after acceptance; stall_req high throughout until done.
REQ-029 MULHU E_a=E_b=0xFFFFFFFF -> result 0xFFFFFFFE. MULH same operands -> result 0x00000000.
REQ-030 DIV E_a=0x80000000, E_b=0xFFFFFFFF -> result 0x80000000, done 1 cycle after acceptance. REM E_a=7, E_b=0 -> result 7.
REQ-031 DIV E_a=-20, E_b=3 -> result 0xFFFFFFFA (-6). REM same operands -> result 0xFFFFFFFE (-2).
REQ-032 E_flush at RUN cycle 10 -> busy low next cycle; no done pulse; a following MUL 3*4 -> result 12.
REQ-033 rst low at RUN cycle 5 -> busy=0, done=0, result=0 immediately (asynchronous); no done pulse after release.
